// File: rtl/cla16_multiword_sequencer_if.sv
// Requester-side bundle of the multiword add/sub sequencer.
// The requester drives the operands and start; the sequencer returns status and result.
interface cla16_multiword_sequencer_if #(
  parameter int WORDS = 4
);
  localparam int N = 16 * WORDS;

  logic         start;
  logic         sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
  logic         overflow;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/cla16_multiword_sequencer.sv
// Drives one shared 16-bit carry-lookahead slice once per cycle, LSW first,
// chaining the carry through a register to add or subtract 16*WORDS-bit operands.
module cla16_multiword_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  cla16_multiword_sequencer_if.slave     bus,
  output logic [15:0]                    add_a,
  output logic [15:0]                    add_b,
  output logic                           add_cin,
  input  logic [15:0]                    add_sum,
  input  logic                           add_cout
);
  localparam int N     = 16 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [IDX_W-1:0] idx_reg;
  logic [N-1:0]     a_reg;
  logic [N-1:0]     b_reg;
  logic             sub_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             overflow_reg;
  logic [15:0]      sum_word_reg [WORDS];
  logic [15:0]      a_word [WORDS];
  logic [15:0]      b_word [WORDS];
  logic [N-1:0]     sum_flat;

  logic accept;
  logic running;
  logic last_word;

  // DONE counts as idle for acceptance, which allows back-to-back operations.
  assign accept    = bus.start && (state_reg != RUN);
  assign running   = (state_reg == RUN);
  assign last_word = (idx_reg == IDX_W'(WORDS - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_word) state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      assign a_word[gi] = a_reg[16*gi +: 16];
      assign b_word[gi] = b_reg[16*gi +: 16];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_word_reg[gi] <= '0;
        end else if (accept) begin
          sum_word_reg[gi] <= '0;
        end else if (running && (idx_reg == IDX_W'(gi))) begin
          sum_word_reg[gi] <= add_sum;
        end
      end
    end
  endgenerate

  // Slice operands come only from registered state, so start never reaches the adder combinationally.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (running) begin
      for (int i = 0; i < WORDS; i++) begin
        if (idx_reg == IDX_W'(i)) begin
          add_a = a_word[i];
          add_b = b_word[i] ^ {16{sub_reg}};
        end
      end
      add_cin = carry_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      sub_reg      <= 1'b0;
      carry_reg    <= 1'b0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg        <= bus.a;
        b_reg        <= bus.b;
        sub_reg      <= bus.sub;
        idx_reg      <= '0;
        // Subtraction is a + ~b + 1 - borrow_in, so the initial carry is the inverted borrow.
        carry_reg    <= bus.sub ? ~bus.cin : bus.cin;
        cout_reg     <= 1'b0;
        overflow_reg <= 1'b0;
      end else if (running) begin
        carry_reg <= add_cout;
        idx_reg   <= idx_reg + 1'b1;
        if (last_word) begin
          cout_reg     <= add_cout;
          overflow_reg <= (add_a[15] == add_b[15]) && (add_sum[15] != add_a[15]);
        end
      end
    end
  end

  always_comb begin
    sum_flat = '0;
    for (int i = 0; i < WORDS; i++) begin
      sum_flat[16*i +: 16] = sum_word_reg[i];
    end
  end

  assign bus.sum      = sum_flat;
  assign bus.busy     = running;
  assign bus.done     = (state_reg == DONE);
  assign bus.cout     = cout_reg;
  assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_cla16_multiword_sequencer.sv
// Scoreboard bench for the multiword sequencer: stimulus pushes model results,
// a monitor pops and compares whenever done is seen.
module tb_cla16_multiword_sequencer;
  localparam int WORDS = 4;
  localparam int N     = 16 * WORDS;

  typedef struct {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;
  logic        add_cout;

  int   n_cmp;
  int   n_err;
  exp_t q[$];

  cla16_multiword_sequencer_if #(.WORDS(WORDS)) bus ();

  cla16_multiword_sequencer #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // Stand-in for the external 16-bit adder slice.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic signed [65:0] SMAX = 66'sd9223372036854775807;
  localparam logic signed [65:0] SMIN = -66'sd9223372036854775808;

  function automatic exp_t model(input logic s, input logic [N-1:0] av, input logic [N-1:0] bv,
                                 input logic c);
    exp_t e;
    logic [N:0] wide;
    logic signed [65:0] sa, sb, sc, sr;
    sa = $signed({{2{av[N-1]}}, av});
    sb = $signed({{2{bv[N-1]}}, bv});
    sc = $signed({65'd0, c});
    if (!s) begin
      wide   = {1'b0, av} + {1'b0, bv} + 65'(c);
      e.sum  = wide[N-1:0];
      e.cout = wide[N];
      sr     = sa + sb + sc;
    end else begin
      e.sum  = av - bv - 64'(c);
      e.cout = ({1'b0, av} >= ({1'b0, bv} + 65'(c)));
      sr     = sa - sb - sc;
    end
    e.ovf = (sr > SMAX) || (sr < SMIN);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Caller is positioned just after a rising edge; start is accepted at the next edge.
  task automatic issue(input logic s, input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic c, input bit expect_result);
    bus.start = 1'b1;
    bus.sub   = s;
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = c;
    if (expect_result) q.push_back(model(s, av, bv, c));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.sub   = 1'($urandom);
    bus.a     = {$urandom, $urandom};
    bus.b     = {$urandom, $urandom};
    bus.cin   = 1'($urandom);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("txn sum=%h cout=%0b ovf=%0b (exp %h %0b %0b)",
                 bus.sum, bus.cout, bus.overflow, e.sum, e.cout, e.ovf);
        chk("sb_sum", bus.sum, e.sum);
        chk("sb_cout", 64'(bus.cout), 64'(e.cout));
        chk("sb_ovf", 64'(bus.overflow), 64'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] cin_seq;
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_sum", bus.sum, 64'd0);
    chk("rst_cout_ovf", {62'd0, bus.cout, bus.overflow}, 64'd0);
    chk("rst_add", {31'd0, add_a, add_b, add_cin}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_done", 64'(bus.done), 64'd0);

    // Carry out of slice 0 into slice 1
    @(posedge clk); #1;
    issue(1'b0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cin_seq[k] = add_cin;
      chk("run_busy", 64'(bus.busy), 64'd1);
    end
    chk("t2_cin_seq", 64'(cin_seq), 64'b0010);
    @(negedge clk);
    chk("t2_done_lat", 64'(bus.done), 64'd1);
    chk("t2_busy_off", 64'(bus.busy), 64'd0);
    chk("t2_sum", bus.sum, 64'h0000_0000_0001_0000);

    // Full ripple
    @(posedge clk); #1;
    issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1);
    wait_done();
    chk("t3_sum", bus.sum, 64'd0);
    chk("t3_cout", 64'(bus.cout), 64'd1);

    // Subtract with borrow
    @(posedge clk); #1;
    issue(1'b1, 64'd5, 64'd7, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_addb0", 64'(add_b), 64'h0000_0000_0000_FFF8);
    wait_done();
    chk("t4_sum", bus.sum, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t4_cout", 64'(bus.cout), 64'd0);

    // Signed overflow both directions
    @(posedge clk); #1;
    issue(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
    wait_done();
    chk("t5_sum", bus.sum, 64'h8000_0000_0000_0000);
    chk("t5_ovf_add", 64'(bus.overflow), 64'd1);
    @(posedge clk); #1;
    issue(1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
    wait_done();
    chk("t5_ovf_sub", 64'(bus.overflow), 64'd1);

    // Start during RUN is ignored
    @(posedge clk); #1;
    issue(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b1, 1'b1);
    repeat (2) @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.sub   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done();
    chk("t6_ignored_sum", bus.sum, 64'h2345_789A_CDF0_2335);

    // Reset mid-RUN aborts
    @(posedge clk); #1;
    issue(1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0101_0101_0101_0101, 1'b0, 1'b0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_sum", bus.sum, 64'd0);
    chk("t6_rst_busy", 64'(bus.busy), 64'd0);
    chk("t6_rst_add_a", 64'(add_a), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t6_no_done", 64'(bus.done), 64'd0);
    end

    // Back-to-back start during DONE
    @(posedge clk); #1;
    issue(1'b0, 64'd100, 64'd23, 1'b0, 1'b1);
    repeat (4) @(posedge clk); #1;
    chk("t6_in_done", 64'(bus.done), 64'd1);
    issue(1'b1, 64'd100, 64'd23, 1'b1, 1'b1);
    @(negedge clk);
    chk("t6_b2b_busy", 64'(bus.busy), 64'd1);
    wait_done();

    // Randomized operations
    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (t % 5 == 0) rb = ~ra;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      issue(1'($urandom), ra, rb, 1'($urandom), 1'b1);
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
